// File: rtl/mul_dispatcher_if.sv
// mul_dispatcher_if: operand, multiplier and result signal bundle for mul_dispatcher
interface mul_dispatcher_if #(parameter int DEPTH = 4);
    logic                   in_valid, in_ready;
    logic [31:0]            in_a, in_b;
    logic                   mul_start, mul_end;
    logic [31:0]            mul_a, mul_b;
    logic [63:0]            mul_prod;
    logic                   out_valid, out_ready;
    logic [63:0]            out_prod;
    logic                   busy, timeout_err;
    logic [$clog2(DEPTH):0] level;
    modport slave (
        input  in_valid, in_a, in_b, mul_end, mul_prod, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_prod, busy, timeout_err, level
    );
    modport master (
        output in_valid, in_a, in_b, mul_end, mul_prod, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_prod, busy, timeout_err, level
    );
endinterface

// File: rtl/mul_dispatcher.sv
// mul_dispatcher: queues operand pairs and feeds them one at a time to an external multiplier
module mul_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input logic              clock,
    input logic              reset,
    mul_dispatcher_if.slave  disp_io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t        state_q;
    logic [63:0]   fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [CW-1:0] wait_cnt_q;
    logic          mul_end_q, mul_start_q, out_valid_q, timeout_err_q;
    logic [31:0]   mul_a_q, mul_b_q;
    logic [63:0]   out_prod_q;
    logic          push, pop, rise;
    // level reaches DEPTH exactly when its top bit is set
    assign disp_io.in_ready    = !level_q[AW];
    assign push                = disp_io.in_valid && !level_q[AW];
    assign pop                 = state_q == IDLE && level_q != '0 && !out_valid_q;
    assign rise                = disp_io.mul_end && !mul_end_q;
    assign level_d             = level_q + (AW+1)'(push) - (AW+1)'(pop);
    assign disp_io.mul_start   = mul_start_q;
    assign disp_io.mul_a       = mul_a_q;
    assign disp_io.mul_b       = mul_b_q;
    assign disp_io.out_valid   = out_valid_q;
    assign disp_io.out_prod    = out_prod_q;
    assign disp_io.busy        = state_q != IDLE;
    assign disp_io.timeout_err = timeout_err_q;
    assign disp_io.level       = level_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            wait_cnt_q    <= '0;
            mul_end_q     <= 1'b0;
            mul_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_prod_q    <= '0;
        end else begin
            mul_end_q <= disp_io.mul_end;
            level_q   <= level_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= {disp_io.in_a, disp_io.in_b};
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (out_valid_q && disp_io.out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    {mul_a_q, mul_b_q} <= fifo_q[rd_ptr_q];
                    rd_ptr_q           <= rd_ptr_q + 1'b1;
                    mul_start_q        <= 1'b1;
                    state_q            <= ISSUE;
                end
                ISSUE: begin
                    mul_start_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= WAIT;
                end
                WAIT: if (rise) begin
                    out_prod_q  <= disp_io.mul_prod;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_q <= 1'b1;
                    state_q       <= IDLE;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
